// File: rtl/led_swipe_detect.sv
// Swipe classifier: tracks one LED position per accepted beat and emits a
// {code, frames, dy, dx} gesture word when displacement crosses DIST_THRESH.
module led_swipe_detect #(
  parameter int COORD_W         = 11,
  parameter int DIST_THRESH     = 200,
  parameter int MAX_FRAMES      = 30,
  parameter int LOST_FRAMES     = 3,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast
);
  localparam int DW = COORD_W + 1;
  localparam logic [DW-1:0] LP_TH    = DW'(DIST_THRESH);
  localparam logic [7:0]    LP_MAX   = 8'(MAX_FRAMES);
  localparam logic [7:0]    LP_LOST  = 8'(LOST_FRAMES);
  localparam logic [15:0]   LP_COOL  = 16'(COOLDOWN_FRAMES);

  typedef enum logic [1:0] {IDLE, TRACK, EMIT, COOLDOWN} state_t;

  state_t               r_state, w_state_nx;
  logic [COORD_W-1:0]   r_start_x, r_start_y;
  logic [7:0]           r_frame_cnt, r_lost_cnt;
  logic [15:0]          r_cd_cnt;
  logic [31:0]          r_tdata;
  logic                 r_tready, r_tvalid;

  logic                 w_acc, w_found;
  logic [COORD_W-1:0]   w_x, w_y;
  logic [DW-1:0]        w_dx, w_dy, w_adx, w_ady;
  logic [2:0]           w_code;
  logic [7:0]           w_frame_nx;

  assign w_acc      = s_axis_tvalid & r_tready;
  assign w_found    = s_axis_tdata[31];
  assign w_x        = s_axis_tdata[COORD_W-1:0];
  assign w_y        = s_axis_tdata[16 +: COORD_W];
  assign w_dx       = {1'b0, w_x} - {1'b0, r_start_x};
  assign w_dy       = {1'b0, w_y} - {1'b0, r_start_y};
  assign w_adx      = w_dx[DW-1] ? -w_dx : w_dx;
  assign w_ady      = w_dy[DW-1] ? -w_dy : w_dy;
  assign w_frame_nx = r_frame_cnt + 8'd1;

  // Horizontal is tested first so equal magnitudes resolve as horizontal.
  always_comb begin
    w_code = 3'd0;
    if (w_adx >= LP_TH && w_adx >= w_ady) w_code = w_dx[DW-1] ? 3'd2 : 3'd1;
    else if (w_ady >= LP_TH)              w_code = w_dy[DW-1] ? 3'd4 : 3'd3;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:     if (w_acc && w_found) w_state_nx = TRACK;
      TRACK:    if (w_acc) begin
                  if (w_found) begin
                    if (w_code != 3'd0) w_state_nx = EMIT;
                  end else if (r_lost_cnt + 8'd1 >= LP_LOST) begin
                    w_state_nx = IDLE;
                  end
                end
      EMIT:     if (m_axis_tready) w_state_nx = (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
      COOLDOWN: if (w_acc && r_cd_cnt + 16'd1 >= LP_COOL) w_state_nx = IDLE;
      default:  w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state     <= IDLE;
      r_start_x   <= '0;
      r_start_y   <= '0;
      r_frame_cnt <= '0;
      r_lost_cnt  <= '0;
      r_cd_cnt    <= '0;
      r_tdata     <= '0;
      r_tready    <= 1'b0;
      r_tvalid    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      // Ready and valid are both derived from the next state, so ready never
      // depends combinationally on m_axis_tready.
      r_tready <= (w_state_nx != EMIT);
      r_tvalid <= (w_state_nx == EMIT);
      case (r_state)
        IDLE: if (w_acc && w_found) begin
          r_start_x   <= w_x;
          r_start_y   <= w_y;
          r_frame_cnt <= '0;
          r_lost_cnt  <= '0;
        end
        TRACK: if (w_acc) begin
          if (w_found) begin
            r_lost_cnt <= '0;
            if (w_code != 3'd0) begin
              r_frame_cnt <= w_frame_nx;
              r_tdata     <= {w_code, w_frame_nx[4:0], 12'(w_dy), 12'(w_dx)};
            end else if (w_frame_nx >= LP_MAX) begin
              r_start_x   <= w_x;
              r_start_y   <= w_y;
              r_frame_cnt <= '0;
            end else begin
              r_frame_cnt <= w_frame_nx;
            end
          end else begin
            r_lost_cnt  <= r_lost_cnt + 8'd1;
            r_frame_cnt <= w_frame_nx;
          end
        end
        EMIT:     if (m_axis_tready) r_cd_cnt <= '0;
        COOLDOWN: if (w_acc) r_cd_cnt <= r_cd_cnt + 16'd1;
        default: ;
      endcase
    end
  end

  assign s_axis_tready = r_tready;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tvalid;
  assign m_axis_tdata  = r_tdata;

  logic w_unused;
  assign w_unused = s_axis_tlast;
endmodule

// File: tb/tb_led_swipe_detect.sv
// Directed bench for led_swipe_detect; inputs driven and outputs sampled on negedge.
module tb_led_swipe_detect;
  logic        ACLK, ARESETN;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;

  int total = 0;
  int bad   = 0;

  led_swipe_detect dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic beat(input bit f, input int x, input int y);
    int n;
    s_axis_tdata  = {f, 4'b0, 11'(y), 5'b0, 11'(x)};
    s_axis_tvalid = 1'b1;
    n = 0;
    while (!s_axis_tready && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(s_axis_tready), 32'd1);
    @(negedge ACLK);
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
  endtask

  task automatic expect_g(input string tag, input logic [31:0] exp);
    chk({tag, "_vld"},  32'(m_axis_tvalid), 32'd1);
    chk({tag, "_data"}, m_axis_tdata, exp);
    chk({tag, "_last"}, 32'(m_axis_tlast), 32'd1);
    chk({tag, "_srdy"}, 32'(s_axis_tready), 32'd0);
    m_axis_tready = 1'b1;
    @(negedge ACLK);
    m_axis_tready = 1'b0;
    chk({tag, "_drop"}, 32'(m_axis_tvalid), 32'd0);
    chk({tag, "_rdy"},  32'(s_axis_tready), 32'd1);
  endtask

  task automatic cool();
    repeat (15) beat(1'b0, 0, 0);
  endtask

  initial begin
    ARESETN = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = '0;
    s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
    repeat (5) begin
      @(negedge ACLK);
      chk("rst_flags", {29'd0, s_axis_tready, m_axis_tvalid, m_axis_tlast}, 32'd0);
      chk("rst_data", m_axis_tdata, 32'd0);
    end
    ARESETN = 1'b1; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
    @(negedge ACLK);
    chk("rst_rdy", 32'(s_axis_tready), 32'd1);

    // right swipe
    beat(1, 100, 200); beat(1, 150, 200);
    beat(1, 250, 200); chk("right_early", 32'(m_axis_tvalid), 32'd0);
    beat(1, 310, 200);
    expect_g("right", 32'h230000D2);
    cool();

    // tie resolves horizontal, then up
    beat(1, 500, 500); beat(1, 300, 300);
    expect_g("tie", 32'h41F38F38);
    cool();
    beat(1, 500, 500); beat(1, 450, 260);
    expect_g("up", 32'h81F10FCE);
    cool();

    // lost LED aborts tracking; next found beat re-anchors
    beat(1, 100, 200);
    repeat (3) begin
      beat(0, 0, 0);
      chk("lost_none", 32'(m_axis_tvalid), 32'd0);
    end
    beat(1, 900, 200);  chk("lost_anchor", 32'(m_axis_tvalid), 32'd0);
    beat(1, 1000, 200); chk("lost_dx100", 32'(m_axis_tvalid), 32'd0);
    beat(1, 1100, 200);
    expect_g("lost_swipe", 32'h220000C8);
    cool();

    // backpressure, then cooldown discards a full swipe
    beat(1, 0, 0); beat(1, 250, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      chk("bp_data", m_axis_tdata, 32'h210000FA);
      chk("bp_vld",  32'(m_axis_tvalid), 32'd1);
      chk("bp_srdy", 32'(s_axis_tready), 32'd0);
    end
    expect_g("bp", 32'h210000FA);
    for (int i = 0; i < 15; i++) begin
      beat(1, (i % 2) ? 500 : 0, 0);
      chk("cd_none", 32'(m_axis_tvalid), 32'd0);
    end
    beat(1, 100, 0); chk("cd16_anchor", 32'(m_axis_tvalid), 32'd0);
    beat(1, 400, 0);
    expect_g("cd16", 32'h2100012C);
    cool();

    // re-anchor after MAX_FRAMES tracked beats
    beat(1, 0, 0);
    for (int i = 1; i <= 31; i++) begin
      beat(1, 5 * i, 0);
      chk("reanc_none", 32'(m_axis_tvalid), 32'd0);
    end
    beat(1, 350, 0);
    expect_g("reanc", 32'h220000C8);
    cool();

    // reset while a gesture is pending
    beat(1, 0, 0); beat(1, 300, 0);
    chk("rstemit_vld", 32'(m_axis_tvalid), 32'd1);
    ARESETN = 1'b0;
    @(negedge ACLK);
    chk("rstemit_flags", {29'd0, s_axis_tready, m_axis_tvalid, m_axis_tlast}, 32'd0);
    chk("rstemit_data", m_axis_tdata, 32'd0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("rstemit_rdy", 32'(s_axis_tready), 32'd1);
    beat(1, 100, 100); chk("rstemit_idle", 32'(m_axis_tvalid), 32'd0);
    beat(1, 100, 400);
    expect_g("down", 32'h6112C000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
